// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one combinational ALU by two valid/ready requesters (req0/req1 in, alu_* out/in, tagged rsp_* out)
module alu_req_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MUL_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shamt,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryFlag,
  input  logic             alu_zeroFlag,
  input  logic             alu_signFlag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic             rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic r_last, r_id, r_rsp_id, r_rsp_carry, r_rsp_zero, r_rsp_sign, r_rsp_err;
  logic [3:0] r_op, r_cnt;
  logic [4:0] r_sh;
  logic [WIDTH-1:0] r_a, r_b, r_rsp_result;
  logic w_idle, w_gnt0, w_gnt1, w_take, w_done, w_ill;
  logic [3:0] w_op_in;
  assign w_idle  = (r_state == IDLE) && !rst;
  assign w_gnt0  = w_idle && req0_valid && (!req1_valid || r_last);
  assign w_gnt1  = w_idle && req1_valid && (!req0_valid || !r_last);
  assign w_take  = w_gnt0 || w_gnt1;
  assign w_op_in = w_gnt1 ? req1_opcode : req0_opcode;
  assign w_done  = (r_state == EXEC) && (r_cnt == 4'd0);
  assign w_ill   = r_op[3];
  assign req0_ready     = w_gnt0;
  assign req1_ready     = w_gnt1;
  assign alu_opcode     = r_op;
  assign alu_input1     = r_a;
  assign alu_input2     = r_b;
  assign alu_shiftValue = r_sh;
  assign rsp_valid      = (r_state == RESP);
  assign rsp_id         = r_rsp_id;
  assign rsp_result     = r_rsp_result;
  assign rsp_carry      = r_rsp_carry;
  assign rsp_zero       = r_rsp_zero;
  assign rsp_sign       = r_rsp_sign;
  assign rsp_err        = r_rsp_err;
  always_comb begin
    w_next = r_state;
    if (w_take) w_next = EXEC;
    else if (w_done) w_next = RESP;
    else if ((r_state == RESP) && rsp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_sign   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_take) begin
        r_op   <= w_op_in;
        r_a    <= w_gnt1 ? req1_a : req0_a;
        r_b    <= w_gnt1 ? req1_b : req0_b;
        r_sh   <= w_gnt1 ? req1_shamt : req0_shamt;
        r_id   <= w_gnt1;
        r_last <= w_gnt1;
        r_cnt  <= (w_op_in == 4'd4) ? 4'(MUL_WAIT) : 4'd0;
      end else if ((r_state == EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        r_rsp_id     <= r_id;
        r_rsp_result <= w_ill ? '0 : alu_result;
        r_rsp_carry  <= !w_ill && alu_carryFlag;
        r_rsp_zero   <= w_ill || alu_zeroFlag;
        r_rsp_sign   <= !w_ill && alu_signFlag;
        r_rsp_err    <= w_ill;
      end
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed self-checking bench with a behavioural stand-in ALU
module tb_alu_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_opcode = 0, req1_opcode = 0, alu_opcode;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [4:0] req0_shamt = 0, req1_shamt = 0, alu_shiftValue;
  logic [15:0] alu_input1, alu_input2, alu_result, rsp_result;
  logic alu_carryFlag, alu_zeroFlag, alu_signFlag;
  logic rsp_valid, rsp_ready = 0, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_err;
  int checks = 0, errors = 0;
  logic [16:0] w_t;
  alu_req_arbiter #(.WIDTH(16), .MUL_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
    .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag), .alu_signFlag(alu_signFlag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  always_comb begin
    w_t = 17'h1ffff;
    case (alu_opcode)
      4'd0: w_t = {1'b0, alu_input1} + {1'b0, alu_input2};
      4'd1: w_t = {1'b0, alu_input1} - {1'b0, alu_input2};
      4'd2: w_t = {1'b0, alu_input1 & alu_input2};
      4'd3: w_t = {1'b0, alu_input1 | alu_input2};
      4'd4: w_t = {1'b0, 16'(alu_input1 * alu_input2)};
      4'd5: w_t = {1'b0, alu_input1 ^ alu_input2};
      4'd6: w_t = {1'b0, alu_input1 << alu_shiftValue};
      4'd7: w_t = {1'b0, alu_input1 >> alu_shiftValue};
      default: w_t = 17'h1ffff;
    endcase
  end
  assign alu_result    = w_t[15:0];
  assign alu_carryFlag = w_t[16];
  assign alu_zeroFlag  = (w_t[15:0] == 16'h0);
  assign alu_signFlag  = w_t[15];
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1; req0_valid = 1;
    tick(); tick(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
    checks++; if (rsp_result !== 16'h0) begin errors++; $display("FAIL reset_rsp_result got %h exp 0000", rsp_result); end
    checks++; if ({rsp_carry, rsp_zero, rsp_sign, rsp_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {rsp_carry, rsp_zero, rsp_sign, rsp_err}); end
    checks++; if ({alu_opcode, alu_input1, alu_input2, alu_shiftValue} !== 41'h0) begin errors++; $display("FAIL reset_alu_ports got %h exp 0", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
    req0_valid = 0;
  endtask
  task automatic test_sll();
    rst = 0; rsp_ready = 1;
    req0_opcode = 4'd6; req0_a = 16'h0001; req0_b = 16'h0; req0_shamt = 5'd4; req0_valid = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL sll_ready got %b exp 10", {req0_ready, req1_ready}); end
    tick(); req0_valid = 0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sll_early_valid got %b exp 0", rsp_valid); end
    tick(); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_err} !== 4'b1000) begin errors++; $display("FAIL sll_rsp_ctl got %b exp 1000", {rsp_valid, rsp_id, rsp_zero, rsp_err}); end
    checks++; if (rsp_result !== 16'h0010) begin errors++; $display("FAIL sll_result got %h exp 0010", rsp_result); end
    tick(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sll_rsp_drop got %b exp 0", rsp_valid); end
  endtask
  task automatic test_round_robin();
    rst = 1; tick(); rst = 0; rsp_ready = 1;
    req0_opcode = 4'd0; req0_a = 16'd3; req0_b = 16'd5; req0_valid = 1;
    req1_opcode = 4'd1; req1_a = 16'd10; req1_b = 16'd3; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got %b", i, {req0_ready, req1_ready}); end
      tick(); tick(); #1;
      checks++; if ({rsp_valid, rsp_id} !== {1'b1, 1'(i % 2)}) begin errors++; $display("FAIL rr_rsp%0d got valid/id %b exp 1%0d", i, {rsp_valid, rsp_id}, i % 2); end
      checks++; if (rsp_result !== ((i % 2 == 0) ? 16'd8 : 16'd7)) begin errors++; $display("FAIL rr_result%0d got %h", i, rsp_result); end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic test_mul();
    req0_opcode = 4'd4; req0_a = 16'h0100; req0_b = 16'h0100; req0_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mul_ready got %b exp 1", req0_ready); end
    tick(); req0_valid = 0; req0_a = 16'hffff; req0_opcode = 4'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({rsp_valid, alu_opcode, alu_input1, alu_input2} !== {1'b0, 4'd4, 16'h0100, 16'h0100}) begin errors++; $display("FAIL mul_exec%0d got valid %b op %h a %h b %h", k, rsp_valid, alu_opcode, alu_input1, alu_input2); end
      tick();
    end
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_err} !== 4'b1010) begin errors++; $display("FAIL mul_rsp_ctl got %b exp 1010", {rsp_valid, rsp_id, rsp_zero, rsp_err}); end
    checks++; if (rsp_result !== 16'h0000) begin errors++; $display("FAIL mul_result got %h exp 0000", rsp_result); end
    tick();
  endtask
  task automatic test_illegal();
    req1_opcode = 4'd9; req1_a = 16'h1234; req1_b = 16'h0005; req1_valid = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL ill_ready got %b exp 01", {req0_ready, req1_ready}); end
    tick(); req1_valid = 0; tick(); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_carry, rsp_sign} !== 6'b111100) begin errors++; $display("FAIL ill_flags got %b exp 111100", {rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_carry, rsp_sign}); end
    checks++; if (rsp_result !== 16'h0) begin errors++; $display("FAIL ill_result got %h exp 0000", rsp_result); end
    tick();
  endtask
  task automatic test_stall();
    rsp_ready = 0;
    req0_opcode = 4'd3; req0_a = 16'h8000; req0_b = 16'h0001; req0_valid = 1;
    tick(); req0_valid = 0; tick(); #1;
    checks++; if ({rsp_valid, rsp_sign, rsp_result} !== {2'b11, 16'h8001}) begin errors++; $display("FAIL stall_first got %b %b %h exp 1 1 8001", rsp_valid, rsp_sign, rsp_result); end
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      checks++; if ({rsp_valid, rsp_id, rsp_sign, rsp_result, req0_ready, req1_ready} !== {3'b101, 16'h8001, 2'b00}) begin errors++; $display("FAIL stall_hold%0d got valid %b id %b sign %b res %h rdy %b%b", k, rsp_valid, rsp_id, rsp_sign, rsp_result, req0_ready, req1_ready); end
    end
    rsp_ready = 1; tick(); #1;
    checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin errors++; $display("FAIL stall_release got %b exp 001", {rsp_valid, req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic test_rst_abort();
    rsp_ready = 1;
    req0_opcode = 4'd4; req0_a = 16'd3; req0_b = 16'd3; req0_valid = 1;
    tick(); req0_valid = 0; tick();
    rst = 1; tick(); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result, alu_opcode, alu_input1} !== 38'h0) begin errors++; $display("FAIL abort_reset got valid %b id %b res %h op %h a %h", rsp_valid, rsp_id, rsp_result, alu_opcode, alu_input1); end
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp%0d got %b exp 0", k, rsp_valid); end
    end
    req0_opcode = 4'd0; req0_a = 16'd1; req0_b = 16'd1; req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL abort_tie got %b exp 10", {req0_ready, req1_ready}); end
    tick(); req0_valid = 0; req1_valid = 0; tick(); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 16'd2}) begin errors++; $display("FAIL abort_next got valid %b id %b res %h", rsp_valid, rsp_id, rsp_result); end
    tick();
  endtask
  initial begin
    test_reset();
    test_sll();
    test_round_robin();
    test_mul();
    test_illegal();
    test_stall();
    test_rst_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
